// File: rtl/dfr_phase_sequencer_if.sv
// Reservoir-step / history / output-MAC handshake bundle for dfr_phase_sequencer.
// master = sequencer side, slave = reservoir + MAC datapath side.
interface dfr_phase_sequencer_if #(
  parameter int IN_ADDR_W   = 16,
  parameter int HIST_ADDR_W = 16,
  parameter int CNT_W       = 32
);
  logic                   step_req;
  logic                   step_ack;
  logic [IN_ADDR_W-1:0]   in_mem_addr;
  logic                   hist_we;
  logic [HIST_ADDR_W-1:0] hist_addr;
  logic                   mac_start;
  logic                   mac_done;
  logic [CNT_W-1:0]       sample_idx;

  modport master (
    output step_req, in_mem_addr, hist_we, hist_addr, mac_start, sample_idx,
    input  step_ack, mac_done
  );

  modport slave (
    input  step_req, in_mem_addr, hist_we, hist_addr, mac_start, sample_idx,
    output step_ack, mac_done
  );
endinterface

// File: rtl/dfr_phase_sequencer.sv
// Run-phase controller for the hybrid DFR core: INIT -> TRAIN -> TEST (with an
// output-MAC firing at every completed TEST sample), step handshake with the
// reservoir path and reservoir-history write addressing.
// Optional feature macro: DFR_SEQ_CYCLE_CNT_EN adds the dbg_cycles busy-cycle counter.
module dfr_phase_sequencer #(
  parameter int IN_ADDR_W   = 16,
  parameter int HIST_ADDR_W = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             preserve_state,
  input  logic [CNT_W-1:0] num_init_steps,
  input  logic [CNT_W-1:0] num_train_steps,
  input  logic [CNT_W-1:0] num_test_steps,
  input  logic [CNT_W-1:0] num_steps_per_sample,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic [1:0]       phase,
  output logic             res_clear,
  dfr_phase_sequencer_if.master rsv
`ifdef DFR_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]      dbg_cycles
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CLEAR, S_INIT, S_TRAIN, S_TEST, S_MAC, S_DONE
  } state_t;

  // One extra headroom pair of bits so the three-way step sum cannot overflow.
  localparam int SW = CNT_W + 2;
  localparam logic [SW-1:0] ADDR_SPACE = {{(SW-1){1'b0}}, 1'b1} << IN_ADDR_W;

  state_t                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   cfg_err_q, cfg_err_d;
  logic [1:0]             phase_q, phase_d;
  logic                   res_clear_q, res_clear_d;
  logic                   step_req_q, step_req_d;
  logic [IN_ADDR_W-1:0]   in_addr_q, in_addr_d;
  logic                   hist_we_q, hist_we_d;
  logic [HIST_ADDR_W-1:0] hist_addr_q, hist_addr_d;
  logic [HIST_ADDR_W-1:0] hist_cnt_q, hist_cnt_d;
  logic                   mac_start_q, mac_start_d;
  logic [CNT_W-1:0]       sample_idx_q, sample_idx_d;
  logic [CNT_W-1:0]       n_init_q, n_init_d;
  logic [CNT_W-1:0]       n_train_q, n_train_d;
  logic [CNT_W-1:0]       n_test_q, n_test_d;
  logic [CNT_W-1:0]       n_sps_q, n_sps_d;
  logic                   preserve_q, preserve_d;
  logic [CNT_W-1:0]       step_cnt_q, step_cnt_d;   // steps done in current phase
  logic [CNT_W-1:0]       smp_cnt_q, smp_cnt_d;     // TEST steps within current sample
  logic [CNT_W-1:0]       cur_n;
  logic [SW-1:0]          step_sum;
`ifdef DFR_SEQ_CYCLE_CNT_EN
  logic [31:0]            dbg_cycles_q, dbg_cycles_d;
`endif

  // Next-state and next-output computation for the whole sequencer.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    cfg_err_d    = cfg_err_q;
    phase_d      = phase_q;
    res_clear_d  = 1'b0;
    step_req_d   = step_req_q;
    in_addr_d    = in_addr_q;
    hist_we_d    = 1'b0;
    hist_addr_d  = hist_addr_q;
    hist_cnt_d   = hist_cnt_q;
    mac_start_d  = 1'b0;
    sample_idx_d = sample_idx_q;
    n_init_d     = n_init_q;
    n_train_d    = n_train_q;
    n_test_d     = n_test_q;
    n_sps_d      = n_sps_q;
    preserve_d   = preserve_q;
    step_cnt_d   = step_cnt_q;
    smp_cnt_d    = smp_cnt_q;
    step_sum     = {2'b00, n_init_q} + {2'b00, n_train_q} + {2'b00, n_test_q};

    cur_n = '0;
    case (state_q)
      S_INIT:  cur_n = n_init_q;
      S_TRAIN: cur_n = n_train_q;
      S_TEST:  cur_n = n_test_q;
      default: cur_n = '0;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_CHECK;
          busy_d       = 1'b1;
          cfg_err_d    = 1'b0;
          phase_d      = 2'd0;
          n_init_d     = num_init_steps;
          n_train_d    = num_train_steps;
          n_test_d     = num_test_steps;
          n_sps_d      = num_steps_per_sample;
          preserve_d   = preserve_state;
          in_addr_d    = '0;
          hist_cnt_d   = '0;
          hist_addr_d  = '0;
          sample_idx_d = '0;
          step_cnt_d   = '0;
          smp_cnt_d    = '0;
        end
      end
      S_CHECK: begin
        if (((n_test_q != '0) && (n_sps_q == '0)) || (step_sum > ADDR_SPACE)) begin
          cfg_err_d = 1'b1;
          done_d    = 1'b1;
          state_d   = S_DONE;
        end else begin
          res_clear_d = ~preserve_q;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d    = S_INIT;
        phase_d    = 2'd0;
        step_cnt_d = '0;
        step_req_d = (n_init_q != '0);
      end
      S_INIT, S_TRAIN, S_TEST: begin
        if (step_req_q) begin
          if (rsv.step_ack) begin
            step_req_d = 1'b0;
            in_addr_d  = in_addr_q + 1'b1;
            step_cnt_d = step_cnt_q + 1'b1;
            if (state_q != S_INIT) begin
              hist_we_d   = 1'b1;
              hist_addr_d = hist_cnt_q;
              hist_cnt_d  = hist_cnt_q + 1'b1;
            end
            if (state_q == S_TEST) begin
              if ((smp_cnt_q + 1'b1) == n_sps_q) begin
                smp_cnt_d   = '0;
                mac_start_d = 1'b1;
                phase_d     = 2'd3;
                state_d     = S_MAC;
              end else begin
                smp_cnt_d = smp_cnt_q + 1'b1;
              end
            end
          end
        end else if (step_cnt_q == cur_n) begin
          // Phase exhausted (or empty): move on, requesting at once if the next phase has work.
          step_cnt_d = '0;
          case (state_q)
            S_INIT: begin
              state_d    = S_TRAIN;
              phase_d    = 2'd1;
              step_req_d = (n_train_q != '0);
            end
            S_TRAIN: begin
              state_d    = S_TEST;
              phase_d    = 2'd2;
              step_req_d = (n_test_q != '0);
            end
            default: begin
              state_d = S_DONE;
              phase_d = 2'd0;
              done_d  = 1'b1;
            end
          endcase
        end else begin
          step_req_d = 1'b1;
        end
      end
      S_MAC: begin
        if (rsv.mac_done) begin
          sample_idx_d = sample_idx_q + 1'b1;
          if (step_cnt_q == n_test_q) begin
            state_d = S_DONE;
            phase_d = 2'd0;
            done_d  = 1'b1;
          end else begin
            state_d    = S_TEST;
            phase_d    = 2'd2;
            step_req_d = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        phase_d = 2'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef DFR_SEQ_CYCLE_CNT_EN
  // Busy-cycle counter: restarts on an accepted launch, saturates, holds once idle.
  always_comb begin
    dbg_cycles_d = dbg_cycles_q;
    if ((state_q == S_IDLE) && start) begin
      dbg_cycles_d = '0;
    end else if (busy_q && (dbg_cycles_q != 32'hFFFF_FFFF)) begin
      dbg_cycles_d = dbg_cycles_q + 1'b1;
    end
  end
`endif

  // State and registered-output flops; reset aborts any run without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      phase_q      <= 2'd0;
      res_clear_q  <= 1'b0;
      step_req_q   <= 1'b0;
      in_addr_q    <= '0;
      hist_we_q    <= 1'b0;
      hist_addr_q  <= '0;
      hist_cnt_q   <= '0;
      mac_start_q  <= 1'b0;
      sample_idx_q <= '0;
      n_init_q     <= '0;
      n_train_q    <= '0;
      n_test_q     <= '0;
      n_sps_q      <= '0;
      preserve_q   <= 1'b0;
      step_cnt_q   <= '0;
      smp_cnt_q    <= '0;
`ifdef DFR_SEQ_CYCLE_CNT_EN
      dbg_cycles_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cfg_err_q    <= cfg_err_d;
      phase_q      <= phase_d;
      res_clear_q  <= res_clear_d;
      step_req_q   <= step_req_d;
      in_addr_q    <= in_addr_d;
      hist_we_q    <= hist_we_d;
      hist_addr_q  <= hist_addr_d;
      hist_cnt_q   <= hist_cnt_d;
      mac_start_q  <= mac_start_d;
      sample_idx_q <= sample_idx_d;
      n_init_q     <= n_init_d;
      n_train_q    <= n_train_d;
      n_test_q     <= n_test_d;
      n_sps_q      <= n_sps_d;
      preserve_q   <= preserve_d;
      step_cnt_q   <= step_cnt_d;
      smp_cnt_q    <= smp_cnt_d;
`ifdef DFR_SEQ_CYCLE_CNT_EN
      dbg_cycles_q <= dbg_cycles_d;
`endif
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign cfg_err         = cfg_err_q;
  assign phase           = phase_q;
  assign res_clear       = res_clear_q;
  assign rsv.step_req    = step_req_q;
  assign rsv.in_mem_addr = in_addr_q;
  assign rsv.hist_we     = hist_we_q;
  assign rsv.hist_addr   = hist_addr_q;
  assign rsv.mac_start   = mac_start_q;
  assign rsv.sample_idx  = sample_idx_q;
`ifdef DFR_SEQ_CYCLE_CNT_EN
  assign dbg_cycles      = dbg_cycles_q;
`endif

endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// Self-checking bench for dfr_phase_sequencer: table vectors, randomized runs
// against a run-level reference model, and hand-written reset / disturbance runs.
module tb_dfr_phase_sequencer;
  localparam int IN_W = 8;
  localparam int HW   = 3;
  localparam int CW   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          preserve_state = 1'b0;
  logic [CW-1:0] num_init_steps = '0;
  logic [CW-1:0] num_train_steps = '0;
  logic [CW-1:0] num_test_steps = '0;
  logic [CW-1:0] num_steps_per_sample = '0;
  logic          busy, done, cfg_err, res_clear;
  logic [1:0]    phase;

  dfr_phase_sequencer_if #(.IN_ADDR_W(IN_W), .HIST_ADDR_W(HW), .CNT_W(CW)) bus ();

  dfr_phase_sequencer #(.IN_ADDR_W(IN_W), .HIST_ADDR_W(HW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .preserve_state(preserve_state),
    .num_init_steps(num_init_steps), .num_train_steps(num_train_steps),
    .num_test_steps(num_test_steps), .num_steps_per_sample(num_steps_per_sample),
    .busy(busy), .done(done), .cfg_err(cfg_err), .phase(phase),
    .res_clear(res_clear), .rsv(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // responder / monitor state
  int ack_dly = 2, mac_dly = 1, req_age = 0, mac_age = 0;
  bit mac_pend = 0, stray_req = 0;
  int n_ack = 0, n_mac = 0, n_coin = 0, n_clr = 0, n_done = 0, n_reqrise = 0, n_phase_bad = 0;
  int cyc = 0, busy_cyc = 0, req_first = -1, done_cyc = 0;
  bit prev_busy = 0, prev_req = 0;
  int hist_log[$];

  typedef struct {
    int i; int t; int s; int sps; bit pres; int ad; int md;
    int x_acks; int x_macs; int x_clr; int x_err;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Step responder: acks each request ack_dly cycles after it is first seen; can inject one stray ack.
  initial begin
    bus.step_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.step_ack = 1'b0;
      if (bus.step_req) begin
        if (req_age >= ack_dly) begin
          bus.step_ack = 1'b1; n_ack++; req_age = 0;
        end else req_age++;
      end else begin
        req_age = 0;
        if (stray_req && busy) begin bus.step_ack = 1'b1; stray_req = 0; end
      end
    end
  end

  // MAC responder: mac_done mac_dly cycles after mac_start is seen.
  initial begin
    bus.mac_done = 1'b0;
    forever begin
      @(negedge clk);
      bus.mac_done = 1'b0;
      if (bus.mac_start) begin
        mac_pend = 1; mac_age = 0;
      end else if (mac_pend) begin
        if (mac_age >= mac_dly) begin bus.mac_done = 1'b1; mac_pend = 0; end
        else mac_age++;
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.hist_we) hist_log.push_back(int'(bus.hist_addr));
      if (bus.mac_start) n_mac++;
      if (bus.hist_we && bus.mac_start) n_coin++;
      if (res_clear) n_clr++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (busy && !prev_busy) begin busy_cyc = cyc; req_first = -1; end
      if (bus.step_req && !prev_req) begin
        n_reqrise++;
        if (req_first < 0) req_first = cyc;
      end
      if ((bus.mac_start && phase != 2'd3) || (bus.hist_we && phase == 2'd0)) n_phase_bad++;
      prev_busy = busy;
      prev_req  = bus.step_req;
    end
  end

  // One complete run, checked against a run-level model of the sequencer.
  task automatic run_case(input string nm, input int i, input int t, input int s, input int sps,
                          input bit pres, input int ad, input int md, input bit disturb,
                          output int m_acks, output int m_macs, output int m_clr, output int m_err);
    int a0, mc0, co0, cl0, d0, rr0, pb0, h0, k;
    longint total;
    bit e;
    int x_acks, x_hist, x_macs, x_clr;
    total  = longint'(i) + t + s;
    e      = (s > 0 && sps == 0) || (total > (longint'(1) << IN_W));
    x_acks = e ? 0 : int'(total);
    x_hist = e ? 0 : t + s;
    x_macs = (e || sps == 0) ? 0 : s / sps;
    x_clr  = (e || pres) ? 0 : 1;

    @(negedge clk);
    ack_dly = ad; mac_dly = md;
    a0 = n_ack; mc0 = n_mac; co0 = n_coin; cl0 = n_clr; d0 = n_done;
    rr0 = n_reqrise; pb0 = n_phase_bad; h0 = hist_log.size();
    num_init_steps = i; num_train_steps = t; num_test_steps = s;
    num_steps_per_sample = sps; preserve_state = pres;
    chk({nm, " busy_before_start"}, busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " busy_after_start"}, busy, 1);
    if (disturb) begin
      repeat (4) @(negedge clk);
      num_init_steps = 40;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      stray_req = 1;
    end
    k = 0;
    while (n_done == d0 && k < 5000) begin @(negedge clk); k++; end
    chk({nm, " done_within_budget"}, (k < 5000) ? 1 : 0, 1);
    repeat (3) @(negedge clk);

    m_acks = n_ack - a0; m_macs = n_mac - mc0; m_clr = n_clr - cl0; m_err = int'(cfg_err);
    chk({nm, " acks"}, m_acks, x_acks);
    chk({nm, " req_pulses"}, n_reqrise - rr0, x_acks);
    chk({nm, " in_mem_addr"}, bus.in_mem_addr, x_acks % (1 << IN_W));
    chk({nm, " hist_we_count"}, hist_log.size() - h0, x_hist);
    for (int j = 0; j < x_hist && (h0 + j) < hist_log.size(); j++)
      chk({nm, " hist_addr"}, hist_log[h0 + j], j % (1 << HW));
    chk({nm, " mac_starts"}, m_macs, x_macs);
    chk({nm, " hist_mac_coincide"}, n_coin - co0, x_macs);
    chk({nm, " sample_idx"}, bus.sample_idx, x_macs);
    chk({nm, " res_clear_pulses"}, m_clr, x_clr);
    chk({nm, " cfg_err"}, m_err, e ? 1 : 0);
    chk({nm, " done_pulses"}, n_done - d0, 1);
    chk({nm, " busy_after_done"}, busy, 0);
    chk({nm, " phase_consistency"}, n_phase_bad - pb0, 0);
    if (e) chk({nm, " done_latency"}, done_cyc - busy_cyc, 1);
    else if (i > 0) chk({nm, " req_latency"}, req_first - busy_cyc, 2);
    $display("run %s: init=%0d train=%0d test=%0d sps=%0d pres=%0d acks=%0d macs=%0d clr=%0d err=%0d",
             nm, i, t, s, sps, pres, m_acks, m_macs, m_clr, m_err);
  endtask

  initial begin
    vec_t vecs[8];
    int ra, rm, rc, re, k, d0;
    vecs[0] = '{100, 0, 100, 100, 1'b0, 2, 1, 200, 1, 1, 0};
    vecs[1] = '{100, 0, 100, 100, 1'b1, 2, 1, 200, 1, 0, 0};
    vecs[2] = '{0, 0, 10, 0, 1'b0, 2, 1, 0, 0, 0, 1};
    vecs[3] = '{0, 5, 4, 2, 1'b0, 1, 0, 9, 2, 1, 0};
    vecs[4] = '{100, 100, 57, 3, 1'b0, 0, 0, 0, 0, 0, 1};
    vecs[5] = '{100, 100, 56, 7, 1'b0, 0, 2, 256, 8, 1, 0};
    vecs[6] = '{0, 0, 0, 0, 1'b0, 1, 1, 0, 0, 1, 0};
    vecs[7] = '{3, 2, 7, 3, 1'b1, 3, 0, 12, 2, 0, 0};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst cfg_err", cfg_err, 0);
    chk("rst phase", phase, 0);
    chk("rst res_clear", res_clear, 0);
    chk("rst step_req", bus.step_req, 0);
    chk("rst in_mem_addr", bus.in_mem_addr, 0);
    chk("rst hist_we", bus.hist_we, 0);
    chk("rst mac_start", bus.mac_start, 0);
    chk("rst sample_idx", bus.sample_idx, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // table-driven vectors
    foreach (vecs[n]) begin
      run_case($sformatf("vec%0d", n), vecs[n].i, vecs[n].t, vecs[n].s, vecs[n].sps,
               vecs[n].pres, vecs[n].ad, vecs[n].md, 1'b0, ra, rm, rc, re);
      chk($sformatf("vec%0d tbl_acks", n), ra, vecs[n].x_acks);
      chk($sformatf("vec%0d tbl_macs", n), rm, vecs[n].x_macs);
      chk($sformatf("vec%0d tbl_clr", n), rc, vecs[n].x_clr);
      chk($sformatf("vec%0d tbl_err", n), re, vecs[n].x_err);
    end

    // restart while busy plus a stray ack during a request gap: both ignored
    run_case("disturb", 6, 0, 0, 0, 1'b0, 2, 0, 1'b1, ra, rm, rc, re);

    // reset in the middle of TEST with step_req high
    @(negedge clk);
    ack_dly = 1; mac_dly = 1;
    num_init_steps = 0; num_train_steps = 0; num_test_steps = 50;
    num_steps_per_sample = 5; preserve_state = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!(phase == 2'd2 && bus.step_req && bus.sample_idx >= 2) && k < 3000) begin
      @(negedge clk); k++;
    end
    chk("midrst reached_test", (k < 3000) ? 1 : 0, 1);
    d0 = n_done;
    rst = 1'b1;
    #1;
    chk("midrst busy", busy, 0);
    chk("midrst step_req", bus.step_req, 0);
    chk("midrst in_mem_addr", bus.in_mem_addr, 0);
    chk("midrst sample_idx", bus.sample_idx, 0);
    chk("midrst phase", phase, 0);
    chk("midrst hist_we", bus.hist_we, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst no_done", n_done - d0, 0);
    $display("run midrst: reset applied in TEST after %0d cycles", k);
    run_case("after_rst", 2, 3, 6, 3, 1'b0, 1, 1, 1'b0, ra, rm, rc, re);

    // randomized runs against the model
    for (int n = 0; n < 25; n++) begin
      run_case($sformatf("rnd%0d", n), $urandom_range(0, 20), $urandom_range(0, 20),
               $urandom_range(0, 20), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, ra, rm, rc, re);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
